// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI-mode command path: FSM encoding,
// frame/CRC constants, common command indices and the serial CRC7 step.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WAIT_R1 = 3'd2,
    RESP    = 3'd3,
    TRAIL   = 3'd4,
    DONE    = 3'd5
  } sd_state_e;

  localparam int         FRAME_BITS = 48;
  localparam logic [6:0] CRC7_POLY  = 7'h09;
  localparam logic [7:0] R1_TIMEOUT = 8'hFF;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD55 = 6'd55;

  // One bit of x^7+x^3+1, MSB-first message order.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; synchronous clear takes priority over enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_r;

  // CRC register: clear, advance by one message bit, or hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      crc_r <= 7'h00;
    end else if (en) begin
      crc_r <= crc7_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// One SPI-mode SD command transaction: frame out on mosi, hunt and capture
// the R1 byte on miso, trailing clocks, then a one-cycle done pulse.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int NCR_MAX    = 8,
  parameter int TRAIL_BITS = 8
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        miso,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic [6:0]  crc7
);

  localparam int                 WAIT_W     = $clog2(NCR_MAX * 8 + 1);
  localparam int                 TRAIL_W    = $clog2(TRAIL_BITS + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(NCR_MAX * 8 - 1);
  localparam logic [TRAIL_W-1:0] TRAIL_LAST = TRAIL_W'(TRAIL_BITS - 1);
  localparam logic [5:0]         BIT_FIRST  = 6'(FRAME_BITS - 1);

  sd_state_e          state_r, state_s;
  logic [39:0]        hdr_r, hdr_s;
  logic [5:0]         bit_cnt_r, bit_cnt_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic [TRAIL_W-1:0] trail_cnt_r, trail_cnt_s;
  logic [5:0]         shift_r, shift_s;
  logic [7:0]         r1_r, r1_s;
  logic               timeout_r, timeout_s;
  logic               mosi_r, mosi_s;
  logic               cs_n_r, busy_r, done_r;

  logic [5:0] next_idx_s;
  logic [5:0] hdr_idx_s;
  logic [2:0] crc_idx_s;
  logic       frame_bit_s;
  logic       crc_clr_s;
  logic       crc_en_s;
  logic [6:0] crc_s;

  // The frame is never stored whole: header bits come from hdr_r and the
  // CRC field is read straight from the accumulator, which finishes with
  // frame[8] on the same edge that frame[8] is loaded into mosi.
  always_comb begin
    next_idx_s = bit_cnt_r - 6'd1;
    hdr_idx_s  = next_idx_s - 6'd8;
    crc_idx_s  = next_idx_s[2:0] - 3'd1;
    if (next_idx_s >= 6'd8) begin
      frame_bit_s = hdr_r[hdr_idx_s];
    end else if (next_idx_s != 6'd0) begin
      frame_bit_s = crc_s[crc_idx_s];
    end else begin
      frame_bit_s = 1'b1;
    end
  end

  sd_crc7 u_crc7 (
    .clk (spi_clk),
    .clr (crc_clr_s),
    .en  (crc_en_s),
    .din (frame_bit_s),
    .crc (crc_s)
  );

  // Next-state and datapath decode for every FSM state.
  always_comb begin
    state_s     = state_r;
    hdr_s       = hdr_r;
    bit_cnt_s   = bit_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    trail_cnt_s = trail_cnt_r;
    shift_s     = shift_r;
    r1_s        = r1_r;
    timeout_s   = timeout_r;
    mosi_s      = 1'b1;
    crc_clr_s   = reset;
    crc_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = CMD;
          hdr_s     = {2'b01, cmd_index, cmd_arg};
          timeout_s = 1'b0;
          bit_cnt_s = BIT_FIRST;
          mosi_s    = 1'b0;
          crc_clr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (bit_cnt_r == 6'd0) begin
          state_s    = WAIT_R1;
          wait_cnt_s = '0;
        end else begin
          bit_cnt_s = bit_cnt_r - 6'd1;
          mosi_s    = frame_bit_s;
          crc_en_s  = (next_idx_s >= 6'd8);
        end
      end
      WAIT_R1: begin
        if (!miso) begin
          state_s   = RESP;
          bit_cnt_s = 6'd6;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s     = TRAIL;
          r1_s        = R1_TIMEOUT;
          timeout_s   = 1'b1;
          trail_cnt_s = TRAIL_LAST;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      RESP: begin
        shift_s = {shift_r[4:0], miso};
        if (bit_cnt_r == 6'd0) begin
          state_s     = TRAIL;
          r1_s        = {1'b0, shift_r, miso};
          trail_cnt_s = TRAIL_LAST;
        end else begin
          bit_cnt_s = bit_cnt_r - 6'd1;
        end
      end
      TRAIL: begin
        if (trail_cnt_r == '0) begin
          state_s = DONE;
        end else begin
          trail_cnt_s = trail_cnt_r - TRAIL_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered pin/status outputs.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_r     <= IDLE;
      hdr_r       <= 40'h0;
      bit_cnt_r   <= 6'd0;
      wait_cnt_r  <= '0;
      trail_cnt_r <= '0;
      shift_r     <= 6'd0;
      r1_r        <= R1_TIMEOUT;
      timeout_r   <= 1'b0;
      mosi_r      <= 1'b1;
      cs_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      hdr_r       <= hdr_s;
      bit_cnt_r   <= bit_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      trail_cnt_r <= trail_cnt_s;
      shift_r     <= shift_s;
      r1_r        <= r1_s;
      timeout_r   <= timeout_s;
      mosi_r      <= mosi_s;
      cs_n_r      <= (state_s == IDLE) || (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
    end
  end

  assign mosi    = mosi_r;
  assign cs_n    = cs_n_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign r1      = r1_r;
  assign timeout = timeout_r;
  assign crc7    = crc_s;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: directed plan scenarios plus
// randomized transactions against a frame/latency model built from the rules.
module tb_sd_cmd_sequencer;
  import sd_pkg::*;

  localparam int NCR_MAX    = 8;
  localparam int TRAIL_BITS = 8;

  logic        spi_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg   = 32'd0;
  logic        miso    = 1'b1;
  logic        mosi, cs_n, busy, done, timeout;
  logic [7:0]  r1;
  logic [6:0]  crc7;

  int checks = 0;
  int errors = 0;

  sd_cmd_sequencer #(.NCR_MAX(NCR_MAX), .TRAIL_BITS(TRAIL_BITS)) dut (
    .spi_clk(spi_clk), .reset(reset), .start(start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .miso(miso), .mosi(mosi), .cs_n(cs_n), .busy(busy),
    .done(done), .r1(r1), .timeout(timeout), .crc7(crc7)
  );

  always #5 spi_clk = ~spi_clk;

  // CRC7 as the remainder of (msg * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, ref_crc7(msg), 1'b1};
  endfunction

  // Cycle number (accept edge = cycle 0 boundary) in which done is high.
  function automatic int ref_latency(input int n_ones);
    if (n_ones >= NCR_MAX * 8) return 48 + NCR_MAX * 8 + TRAIL_BITS + 1;
    return 48 + (n_ones + 1) + 7 + TRAIL_BITS + 1;
  endfunction

  // miso seen at edge k after accept: ones, then the R1 byte, then idle ones.
  function automatic logic miso_for(input int k, input int n_ones, input logic [7:0] rb);
    int j;
    j = k - 49;
    if (j < n_ones) return 1'b1;
    j = j - n_ones;
    if (j < 8) return rb[7 - j];
    return 1'b1;
  endfunction

  // Drives one transaction and records what the pins did; callers compare.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int n_ones,
                         input logic [7:0] rb, input int glitch_cyc, input bit pulse_done,
                         output logic [47:0] seen, output int d_cyc, output int pulses,
                         output int bad, output logic [7:0] r1_seen, output logic to_seen,
                         output logic [6:0] crc_seen, output logic to_at1,
                         output logic busy_after);
    int cyc;
    bit fin;
    seen = '0; d_cyc = -1; pulses = 0; bad = 0; r1_seen = 8'h00; to_seen = 1'b0;
    crc_seen = 7'h00; to_at1 = 1'b1; busy_after = 1'b1;
    cmd_index = idx; cmd_arg = arg; miso = 1'b1; start = 1'b1;
    @(posedge spi_clk); #1;
    start = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
    cyc = 1; fin = 1'b0;
    while (!fin) begin
      if (cyc == 1) to_at1 = timeout;
      if (cyc <= 48) seen[48 - cyc] = mosi;
      if (cyc == 48) crc_seen = crc7;
      if (done) begin
        pulses++;
        if (d_cyc < 0) begin d_cyc = cyc; r1_seen = r1; to_seen = timeout; end
        if (!cs_n || !busy) bad++;
      end else if (d_cyc < 0) begin
        if (cs_n || !busy) bad++;
        if (cyc > 48 && !mosi) bad++;
      end
      if (d_cyc >= 0 && cyc == d_cyc + 1) begin
        busy_after = busy; fin = 1'b1;
      end else if (cyc >= 400) begin
        fin = 1'b1;
      end else begin
        start = (cyc == glitch_cyc) || (pulse_done && done);
        miso  = miso_for(cyc, n_ones, rb);
        @(posedge spi_clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  logic [47:0] seen;
  int          d_cyc, pulses, bad;
  logic [7:0]  r1_seen;
  logic        to_seen, to_at1, busy_after;
  logic [6:0]  crc_seen;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; miso = 1'b1;
    repeat (3) @(posedge spi_clk);
    #1;
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b exp 1", mosi); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL reset_r1 got %h exp ff", r1); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (crc7 !== 7'h00) begin errors++; $display("FAIL reset_crc7 got %h exp 00", crc7); end
    reset = 1'b0;
    @(posedge spi_clk); #1;
  endtask

  task automatic test_cmd0();
    run_txn(CMD0, 32'h0, 16, 8'h01, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen !== 48'h400000000095) begin errors++; $display("FAIL cmd0_frame got %h exp 400000000095", seen); end
    checks++; if (crc_seen !== 7'h4A) begin errors++; $display("FAIL cmd0_crc7 got %h exp 4a", crc_seen); end
    checks++; if (r1_seen !== 8'h01 || to_seen !== 1'b0) begin errors++; $display("FAIL cmd0_r1 got %h/%b exp 01/0", r1_seen, to_seen); end
    checks++; if (d_cyc != 48 + 17 + 7 + 8 + 1) begin errors++; $display("FAIL cmd0_latency got %0d exp 81", d_cyc); end
    checks++; if (bad != 0 || pulses != 1) begin errors++; $display("FAIL cmd0_pins got bad=%0d pulses=%0d exp 0/1", bad, pulses); end
  endtask

  task automatic test_cmd8();
    run_txn(CMD8, 32'h000001AA, 0, 8'h01, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen !== 48'h48000001AA87) begin errors++; $display("FAIL cmd8_frame got %h exp 48000001aa87", seen); end
    checks++; if (crc_seen !== 7'h43) begin errors++; $display("FAIL cmd8_crc7 got %h exp 43", crc_seen); end
    checks++; if (r1_seen !== 8'h01) begin errors++; $display("FAIL cmd8_r1 got %h exp 01", r1_seen); end
    checks++; if (d_cyc != ref_latency(0)) begin errors++; $display("FAIL cmd8_latency got %0d exp %0d", d_cyc, ref_latency(0)); end
  endtask

  task automatic test_timeout();
    logic [5:0]  idx;
    logic [31:0] arg;
    idx = CMD55; arg = $urandom;
    run_txn(idx, arg, 1000, 8'h00, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen !== ref_frame(idx, arg)) begin errors++; $display("FAIL to_frame got %h exp %h", seen, ref_frame(idx, arg)); end
    checks++; if (r1_seen !== 8'hFF || to_seen !== 1'b1) begin errors++; $display("FAIL to_r1 got %h/%b exp ff/1", r1_seen, to_seen); end
    checks++; if (d_cyc != 48 + 64 + 8 + 1) begin errors++; $display("FAIL to_latency got %0d exp 121", d_cyc); end
    checks++; if (bad != 0 || pulses != 1) begin errors++; $display("FAIL to_pins got bad=%0d pulses=%0d exp 0/1", bad, pulses); end
    run_txn(CMD17, 32'h1234_5678, 5, 8'h7E, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (to_at1 !== 1'b0) begin errors++; $display("FAIL to_clear_on_accept got %b exp 0", to_at1); end
    checks++; if (r1_seen !== 8'h7E || to_seen !== 1'b0) begin errors++; $display("FAIL to_next_r1 got %h/%b exp 7e/0", r1_seen, to_seen); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] arg;
    arg = $urandom;
    run_txn(CMD17, arg, 2, 8'h01, 10, 1'b1, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen !== ref_frame(CMD17, arg)) begin errors++; $display("FAIL ign_frame got %h exp %h", seen, ref_frame(CMD17, arg)); end
    checks++; if (pulses != 1 || bad != 0) begin errors++; $display("FAIL ign_pulses got pulses=%0d bad=%0d exp 1/0", pulses, bad); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy=%b exp 0", busy_after); end
    repeat (3) begin
      @(posedge spi_clk); #1;
      checks++; if (busy !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b1) begin errors++; $display("FAIL ign_idle got busy=%b cs_n=%b mosi=%b exp 0/1/1", busy, cs_n, mosi); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_index = CMD0; cmd_arg = 32'h0; miso = 1'b1; start = 1'b1;
    @(posedge spi_clk); #1;
    start = 1'b0;
    repeat (27) begin @(posedge spi_clk); #1; end
    checks++; if (mosi !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rmid_bit20 got mosi=%b busy=%b exp 0/1", mosi, busy); end
    reset = 1'b1;
    @(posedge spi_clk); #1;
    reset = 1'b0;
    checks++; if (mosi !== 1'b1 || cs_n !== 1'b1) begin errors++; $display("FAIL rmid_pins got mosi=%b cs_n=%b exp 1/1", mosi, cs_n); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_busy got busy=%b done=%b exp 0/0", busy, done); end
    checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL rmid_r1 got %h exp ff", r1); end
    run_txn(CMD0, 32'h0, 1, 8'h01, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen[7:0] !== 8'h95 || seen !== 48'h400000000095) begin errors++; $display("FAIL rmid_frame got %h exp 400000000095", seen); end
    checks++; if (r1_seen !== 8'h01 || d_cyc != ref_latency(1)) begin errors++; $display("FAIL rmid_txn got r1=%h lat=%0d exp 01/%0d", r1_seen, d_cyc, ref_latency(1)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] arg;
    arg = $urandom;
    run_txn(CMD55, 32'h0, 3, 8'h05, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (r1_seen !== 8'h05 || d_cyc != ref_latency(3)) begin errors++; $display("FAIL b2b_first got r1=%h lat=%0d exp 05/%0d", r1_seen, d_cyc, ref_latency(3)); end
    run_txn(CMD17, arg, 7, 8'h00, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
    checks++; if (seen !== ref_frame(CMD17, arg) || bad != 0) begin errors++; $display("FAIL b2b_second got %h bad=%0d exp %h", seen, bad, ref_frame(CMD17, arg)); end
    checks++; if (r1_seen !== 8'h00 || d_cyc != ref_latency(7)) begin errors++; $display("FAIL b2b_second_r1 got r1=%h lat=%0d exp 00/%0d", r1_seen, d_cyc, ref_latency(7)); end
  endtask

  task automatic test_random();
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  rb, exp_r1;
    int          n;
    for (int t = 0; t < 8; t++) begin
      idx = 6'($urandom); arg = $urandom; rb = {1'b0, 7'($urandom)};
      n = $urandom_range(0, 75);
      exp_r1 = (n >= NCR_MAX * 8) ? 8'hFF : rb;
      run_txn(idx, arg, n, rb, 0, 1'b0, seen, d_cyc, pulses, bad, r1_seen, to_seen, crc_seen, to_at1, busy_after);
      checks++; if (seen !== ref_frame(idx, arg) || crc_seen !== ref_crc7({2'b01, idx, arg})) begin errors++; $display("FAIL rnd_frame t=%0d got %h/%h exp %h", t, seen, crc_seen, ref_frame(idx, arg)); end
      checks++; if (r1_seen !== exp_r1 || to_seen !== (n >= NCR_MAX * 8)) begin errors++; $display("FAIL rnd_r1 t=%0d n=%0d got %h/%b exp %h", t, n, r1_seen, to_seen, exp_r1); end
      checks++; if (d_cyc != ref_latency(n) || pulses != 1 || bad != 0) begin errors++; $display("FAIL rnd_timing t=%0d got lat=%0d pulses=%0d bad=%0d exp %0d/1/0", t, d_cyc, pulses, bad, ref_latency(n)); end
      repeat ($urandom_range(0, 3)) begin @(posedge spi_clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences one SD-card SPI-mode command transaction.
- Frames a 48-bit command: start bits, index, argument, CRC7 and end bit.
- Shifts the frame out on mosi, then hunts for and captures the 8-bit R1 response from miso.
- Sits between the card-init / block-transfer controller (which issues start) and the SPI pins; all logic runs on spi_clk.

Parameters:
- NCR_MAX, 8: maximum response latency in bytes. The R1 search aborts after NCR_MAX*8 samples of 1.
- TRAIL_BITS, 8: spi_clk cycles with cs_n low and mosi=1 after R1, before done.

Ports:
- spi_clk  input  1  clock; all state updates on its posedge
- reset  input  1  synchronous, active-high
- start  input  1  request pulse; accepted only when busy=0
- cmd_index  input  6  command number, latched on accept
- cmd_arg  input  32  command argument, latched on accept
- miso  input  1  card data out
- mosi  output  1  registered serial command bit
- cs_n  output  1  registered card select, active low
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- r1  output  8  captured R1 byte; 8'hFF on timeout
- timeout  output  1  sticky until next accept; set when no R1 start bit is seen
- crc7  output  7  CRC7 of the last framed command, valid from the cycle the end bit is driven

Behaviour:
- Reset values: mosi=1, cs_n=1, busy=0, done=0, r1=8'hFF, timeout=0, crc7=0, state=IDLE. Reset has priority over everything, including mid-transaction; the state returns to IDLE on the next edge.
- IDLE:
  - mosi=1, cs_n=1.
  - On the edge where start=1: latch cmd_index/cmd_arg, clear timeout, go to CMD.
  - On that same edge, register mosi=frame[47] and cs_n=0.
- Frame, MSB first: frame[47]=0, [46]=1, [45:40]=cmd_index, [39:8]=cmd_arg, [7:1]=crc7, [0]=1.
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0 at accept.
  - Computed serially over frame[47:8], one bit per cycle as each bit is emitted.
  - crc7 bits must appear on mosi with no gap cycle after frame[8].
- CMD: one frame bit per edge. 48 consecutive mosi values, bit counter 47 down to 0. After frame[0], the next edge enters WAIT_R1 with mosi=1.
- WAIT_R1:
  - mosi=1, cs_n=0. miso is sampled every edge.
  - First sample of 0 is r1[7]; go to RESP.
  - If NCR_MAX*8 consecutive samples are 1: r1=8'hFF, timeout=1, go to TRAIL.
- RESP: the next 7 samples are r1[6:0], MSB first; r1 updates only when complete. Then go to TRAIL.
- TRAIL: TRAIL_BITS cycles with mosi=1, cs_n=0. Then go to DONE.
- DONE: one cycle with done=1, busy=1, cs_n=1. Next edge goes to IDLE. r1, timeout and crc7 hold until the next accept.
- start while busy=1 (including the DONE cycle) is ignored; no queueing.
- Latency from accept edge to done: 48 + (samples in WAIT_R1) + 7 (0 if timeout) + TRAIL_BITS + 1 cycles.
- Counters:
  - bit counter 6 bits.
  - wait counter ceil(log2(NCR_MAX*8+1)) bits.
  - trail counter ceil(log2(TRAIL_BITS+1)) bits.
  - No wrap is permitted; each counter is reloaded on state entry.

Decomposition:
- Shared package (sd_pkg):
  - state encoding IDLE/CMD/WAIT_R1/RESP/TRAIL/DONE
  - FRAME_BITS=48
  - CRC7_POLY=7'h09
  - R1_TIMEOUT=8'hFF
  - command constants CMD0=6'd0, CMD8=6'd8, CMD17=6'd17, CMD55=6'd55
- Sub-module sd_crc7: ports clk, clr, en, din, crc[6:0]; serial CRC7 with the same synchronous clear rule.
- The sequencer owns the FSM, shifter and counters.

Test Plan:
- CMD0, arg 0, miso=1 for 16 samples then 0x01 → mosi frame 40 00 00 00 00 95, crc7=7'h4A, r1=8'h01, timeout=0. done arrives 48+17+7+8+1 cycles after accept.
- CMD8, arg 32'h000001AA, R1 0x01 on first sample → frame 48 00 00 01 AA 87, crc7=7'h43, r1=8'h01.
- miso held 1 throughout (NCR_MAX=8) → after exactly 64 WAIT_R1 samples: r1=8'hFF, timeout=1, then 8 trail cycles and done. Next accept clears timeout.
- start pulsed during CMD and during DONE → ignored: exactly one frame emitted, one done pulse, latched cmd unchanged.
- reset asserted at frame bit 20 → next edge mosi=1, cs_n=1, busy=0, r1=8'hFF. A new CMD0 then completes normally with correct CRC 0x95.
- R1 = 0x05 with the start bit after 3 ones; back-to-back start on the cycle after done → r1=8'h05. Second transaction accepted with mosi=frame[47] on that edge.
